bp_mem_1rw_requester: RTL and testbench
=======================================

Name: bp_mem_1rw_requester

Overview:
Requester-side controller that drives one single-port (1rw) hard-memory wrapper through its clk/v/w/addr/data/mask port.
- Presents a ready/valid request interface to a client (cache or directory pipe).
- Handles the fixed 1-cycle read latency of the macro and buffers returned read data in a small credit-managed FIFO with a valid/yumi handshake.
- Optionally zero-fills the whole array after reset before accepting client traffic.

Parameters:
els_p, 512, number of memory words
width_p, 64, data width in bits
addr_width_p, $clog2(els_p), address width (derived)
ret_els_p, 3, read-return FIFO depth (3 sustains 1 read/cycle under continuous yumi)
init_p, 1, 1 = zero-fill array after reset; 0 = go straight to RUN

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
v_i  in  1  client request valid
ready_o  out  1  client request ready; request accepted when v_i & ready_o
w_i  in  1  1 = write, 0 = read
addr_i  in  addr_width_p  request address
data_i  in  width_p  write data
w_mask_i  in  width_p  bit write mask (1 = write bit)
v_o  out  1  read data valid
data_o  out  width_p  read data (FIFO head)
yumi_i  in  1  client consumes data_o this cycle; legal only when v_o
init_done_o  out  1  high once in RUN
mem_v_o  out  1  to wrapper v_i
mem_w_o  out  1  to wrapper w_i
mem_addr_o  out  addr_width_p  to wrapper addr_i
mem_data_o  out  width_p  to wrapper data_i
mem_w_mask_o  out  width_p  to wrapper w_mask_i
mem_data_i  in  width_p  from wrapper data_o, valid the cycle after a read

Behaviour:
Reset (async, any cycle):
- State enters INIT (init_p=1) or RUN (init_p=0).
- Init counter, FIFO pointers/occupancy and in-flight flag are cleared.
- ready_o=0, v_o=0, init_done_o=0 (init_done_o=1 when init_p=0, after deassert).
- All mem_* outputs are forced to 0 combinationally while reset_i is high.
- Read data in flight at reset is discarded.

State INIT:
- Each cycle drive mem_v_o=1, mem_w_o=1, mem_addr_o=cnt, mem_data_o=0, mem_w_mask_o=all-ones, then cnt++.
- When cnt==els_p-1 is written, go to RUN on the next edge.
- Exactly els_p write cycles occur; ready_o=0 throughout and client v_i is ignored.

State RUN:
- init_done_o=1.
- ready_o = (ret_occ + inflight) < ret_els_p. This depends only on registered state and never on v_i or w_i.
- On accept, mem_* are driven combinationally from the request: mem_v_o=1, mem_w_o=w_i, plus address, data and mask.
- With no accept, mem_v_o=0; other mem_* are don't-care and are held at 0.
- Writes reserve no credit but still require ready_o=1.

Reads:
- inflight register is set on the edge ending an accepted read (cycle N).
- In cycle N+1, mem_data_i is pushed into the FIFO at the closing edge.
- v_o rises in cycle N+2, so read latency is 2 cycles.
- Returns are strictly in request order.

FIFO:
- Push and pop may occur in the same cycle; occupancy is unchanged.
- Push when full is impossible by credit. Any such push, or yumi_i without v_o, is an assertion failure.
- data_o is stable while v_o=1 and no yumi_i.

Decomposition:
- Package bp_mem_1rw_pkg holds:
  - state enum (e_init, e_run);
  - a request struct {w, addr, data, mask} parameterised by width_p/addr_width_p;
  - the constant for memory read latency (1).
- Sub-module bp_mem_1rw_ret_fifo: ret_els_p-deep, width_p-wide FIFO.
  - Ports: push v, data; pop yumi; outputs v, data, occupancy.
  - Same async reset.
- Top-level RTL holds the FSM, init counter, credit logic and mem port muxing.

Test Plan:
- els_p=512, init_p=1, release reset → exactly 512 mem writes to addr 0..511, data 0, mask all-ones; init_done_o and ready_o rise on cycle 513; v_i held high before that is never accepted.
- Write data 64'hDEAD_BEEF_0000_0001 to addr 5 with full mask, then read addr 5 → v_o asserts 2 cycles after the read accept with data_o=64'hDEAD_BEEF_0000_0001.
- Write 64'hFFFF_FFFF_FFFF_FFFF to addr 7, then write 0 to addr 7 with mask 64'h0000_0000_FFFF_FFFF, then read addr 7 → 64'hFFFF_FFFF_0000_0000.
- 16 back-to-back reads of addr 0..15 with yumi_i tied to v_o → ready_o stays 1; one return per cycle from cycle 2; data in address order.
- yumi_i=0 while reads are issued → exactly 3 reads accepted, then ready_o=0. Raise yumi_i → 3 returns in order, and ready_o returns to 1 the cycle after the first pop.
- Assert reset_i mid-cycle with 2 entries buffered and 1 read in flight → v_o, ready_o, init_done_o and mem_v_o drop immediately; after release, INIT restarts at addr 0 and the stale return never appears on data_o.

Source files
------------

// File: rtl/bp_mem_1rw_pkg.sv
// Shared state encoding and timing constants for the single-port memory requester.
// The request struct lives in the top because it depends on that module's width parameters.
package bp_mem_1rw_pkg;

    typedef enum logic [0:0] {
        e_init = 1'b0,
        e_run  = 1'b1
    } bp_mem_1rw_state_e;

    // Cycles between a read strobe on the macro and its data appearing on mem_data_i.
    localparam int unsigned mem_rd_lat_lp = 1;

endpackage

// File: rtl/bp_mem_1rw_requester_chk.sv
// Protocol checks for the requester: client yumi discipline and return-buffer overflow.
module bp_mem_1rw_requester_chk (
    input logic clk_i,
    input logic reset_i,
    input logic yumi_i,
    input logic ret_v_i,
    input logic ret_push_i,
    input logic ret_full_i
);

    yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> ret_v_i);

    // Credit accounting should make this unreachable.
    no_push_when_full_a: assert property (@(posedge clk_i) disable iff (reset_i) ret_push_i |-> !ret_full_i);

endmodule

// File: rtl/bp_mem_1rw_ret_fifo.sv
// Small circular buffer that holds read data returned by the memory macro
// until the client takes it with yumi.
module bp_mem_1rw_ret_fifo #(
    parameter  int els_p    = 3,
    parameter  int width_p  = 64,
    localparam int occ_w_lp = $clog2(els_p + 1),
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                v_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                yumi_i,
    output logic                v_o,
    output logic [width_p-1:0]  data_o,
    output logic [occ_w_lp-1:0] occ_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_q;
    logic [ptr_w_lp-1:0] wr_ptr_q;
    logic [occ_w_lp-1:0] occ_q;
    logic [occ_w_lp-1:0] occ_d;
    logic                pop_s;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] ptr);
        if (ptr == ptr_w_lp'(els_p - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = ptr + ptr_w_lp'(1);
        end
    endfunction

    // An illegal yumi on an empty buffer must not wrap the occupancy counter.
    assign pop_s  = yumi_i & v_o;
    assign v_o    = (occ_q != '0);
    assign data_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        occ_d = occ_q;
        case ({v_i, pop_s})
            2'b10:   occ_d = occ_q + occ_w_lp'(1);
            2'b01:   occ_d = occ_q - occ_w_lp'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            occ_q <= occ_d;
            if (v_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Data storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_mem_1rw_requester.sv
// Client-facing controller for one single-port memory macro: optional zero-fill after
// reset, then credit-limited request issue with buffered read returns.
module bp_mem_1rw_requester
    import bp_mem_1rw_pkg::*;
#(
    parameter int els_p        = 512,
    parameter int width_p      = 64,
    parameter int addr_width_p = $clog2(els_p),
    parameter int ret_els_p    = 3,
    parameter int init_p       = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic                    w_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [width_p-1:0]      data_i,
    input  logic [width_p-1:0]      w_mask_i,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    yumi_i,
    output logic                    init_done_o,
    output logic                    mem_v_o,
    output logic                    mem_w_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic [width_p-1:0]      mem_data_o,
    output logic [width_p-1:0]      mem_w_mask_o,
    input  logic [width_p-1:0]      mem_data_i
);

    localparam int occ_w_lp  = $clog2(ret_els_p + 1);
    localparam int cred_w_lp = occ_w_lp + 1;

    typedef struct packed {
        logic                    w;
        logic [addr_width_p-1:0] addr;
        logic [width_p-1:0]      data;
        logic [width_p-1:0]      mask;
    } bp_mem_1rw_req_t;

    bp_mem_1rw_state_e        state_q;
    logic [addr_width_p-1:0]  cnt_q;
    logic [mem_rd_lat_lp-1:0] inflight_q;
    logic [occ_w_lp-1:0]      ret_occ_s;
    logic                     ret_push_s;
    logic                     ret_full_s;
    logic                     credit_ok_s;
    logic                     accept_s;
    logic                     rd_accept_s;
    logic                     mem_v_s;
    bp_mem_1rw_req_t          client_req_s;
    bp_mem_1rw_req_t          mem_req_s;

    // Every read occupies a credit from acceptance until the client pops its data.
    assign credit_ok_s = (cred_w_lp'(ret_occ_s) + cred_w_lp'($countones(inflight_q)))
                         < cred_w_lp'(ret_els_p);
    assign ready_o     = ~reset_i & (state_q == e_run) & credit_ok_s;
    assign init_done_o = ~reset_i & (state_q == e_run);
    assign accept_s    = v_i & ready_o;
    assign rd_accept_s = accept_s & ~w_i;
    assign ret_push_s  = inflight_q[mem_rd_lat_lp-1];
    assign ret_full_s  = (ret_occ_s == occ_w_lp'(ret_els_p));

    assign client_req_s.w    = w_i;
    assign client_req_s.addr = addr_i;
    assign client_req_s.data = data_i;
    assign client_req_s.mask = w_mask_i;

    // Memory port mux: zero-fill writes during INIT, accepted client requests in RUN.
    always_comb begin
        mem_v_s   = 1'b0;
        mem_req_s = '0;
        if (reset_i) begin
            mem_v_s = 1'b0;
        end else if (state_q == e_init) begin
            mem_v_s        = 1'b1;
            mem_req_s.w    = 1'b1;
            mem_req_s.addr = cnt_q;
            mem_req_s.data = '0;
            mem_req_s.mask = '1;
        end else if (accept_s) begin
            mem_v_s   = 1'b1;
            mem_req_s = client_req_s;
        end else begin
            mem_v_s = 1'b0;
        end
    end

    assign mem_v_o      = mem_v_s;
    assign mem_w_o      = mem_req_s.w;
    assign mem_addr_o   = mem_req_s.addr;
    assign mem_data_o   = mem_req_s.data;
    assign mem_w_mask_o = mem_req_s.mask;

    // Control FSM, init counter and read-in-flight pipeline.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= (init_p != 0) ? e_init : e_run;
            cnt_q      <= '0;
            inflight_q <= '0;
        end else begin
            case (state_q)
                e_init: begin
                    cnt_q      <= cnt_q + addr_width_p'(1);
                    inflight_q <= '0;
                    if (cnt_q == addr_width_p'(els_p - 1)) begin
                        state_q <= e_run;
                    end else begin
                        state_q <= e_init;
                    end
                end
                e_run: begin
                    state_q    <= e_run;
                    inflight_q <= (inflight_q << 1) | mem_rd_lat_lp'(rd_accept_s);
                end
                default: begin
                    state_q    <= e_run;
                    inflight_q <= '0;
                end
            endcase
        end
    end

    bp_mem_1rw_ret_fifo #(
        .els_p   (ret_els_p),
        .width_p (width_p)
    ) ret_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (ret_push_s),
        .data_i  (mem_data_i),
        .yumi_i  (yumi_i),
        .v_o     (v_o),
        .data_o  (data_o),
        .occ_o   (ret_occ_s)
    );

    bp_mem_1rw_requester_chk chk (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .yumi_i     (yumi_i),
        .ret_v_i    (v_o),
        .ret_push_i (ret_push_s),
        .ret_full_i (ret_full_s)
    );

endmodule

// File: tb/tb_bp_mem_1rw_requester.sv
// Directed and random bench for bp_mem_1rw_requester with a behavioural macro model
// and a queue-based scoreboard of outstanding reads.
module tb_bp_mem_1rw_requester;

    localparam int els_lp = 512;
    localparam int aw_lp  = 9;
    localparam int ret_lp = 3;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             v_i = 1'b0;
    logic             w_i = 1'b0;
    logic             yumi_i = 1'b0;
    logic [aw_lp-1:0] addr_i = '0;
    logic [63:0]      data_i = '0;
    logic [63:0]      w_mask_i = '0;
    logic             ready_o, v_o, init_done_o, mem_v_o, mem_w_o;
    logic [63:0]      data_o, mem_data_o, mem_w_mask_o;
    logic [63:0]      mem_data_i = '0;
    logic [aw_lp-1:0] mem_addr_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_acc = 0;
    logic [63:0] last_pop = '0;

    logic [63:0] wmem [els_lp];
    bit          wvalid [els_lp];
    logic [63:0] ref_mem [els_lp];
    logic [63:0] exp_q [$];
    int          acc_q [$];

    bp_mem_1rw_requester #(
        .els_p(512), .width_p(64), .addr_width_p(9), .ret_els_p(3), .init_p(1)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
        .addr_i(addr_i), .data_i(data_i), .w_mask_i(w_mask_i), .v_o(v_o), .data_o(data_o),
        .yumi_i(yumi_i), .init_done_o(init_done_o), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o),
        .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Single-port macro: bit-masked writes, read data one cycle later, junk otherwise.
    always @(posedge clk_i) begin
        if (mem_v_o && mem_w_o) begin
            wmem[mem_addr_o]   <= (wmem[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
            wvalid[mem_addr_o] <= 1'b1;
            mem_data_i         <= {$urandom, $urandom};
        end else if (mem_v_o && wvalid[mem_addr_o]) begin
            mem_data_i <= wmem[mem_addr_o];
        end else begin
            mem_data_i <= {$urandom, $urandom};
        end
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One client cycle: drive at the falling edge, then check against the scoreboard.
    task automatic step(input logic v, input logic w, input logic [aw_lp-1:0] a,
                        input logic [63:0] d, input logic [63:0] m, input logic y);
        logic exp_rdy;
        logic exp_v;
        @(negedge clk_i);
        v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m;
        yumi_i = y & v_o;
        #1;
        exp_rdy = (exp_q.size() < ret_lp);
        exp_v   = (acc_q.size() > 0) && (acc_q[0] + 2 <= cyc);
        chk("ready", 192'(ready_o), 192'(exp_rdy));
        chk("v_o", 192'(v_o), 192'(exp_v));
        chk("init_done", 192'(init_done_o), 192'(1'b1));
        if (v_i && ready_o) n_acc++;
        if (yumi_i && exp_q.size() > 0) begin
            last_pop = exp_q.pop_front();
            void'(acc_q.pop_front());
            chk("ret_data", 192'(data_o), 192'(last_pop));
        end
        if (v && exp_rdy) begin
            chk("mem_req", 192'({mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o}),
                192'({1'b1, w, a, d, m}));
            if (w) begin
                ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            end else begin
                exp_q.push_back(ref_mem[a]);
                acc_q.push_back(cyc);
            end
        end else begin
            chk("mem_idle", 192'(mem_v_o), 192'(1'b0));
        end
        cyc++;
    endtask

    // Release reset with v_i held high and expect exactly els_lp zero-fill writes.
    task automatic init_phase();
        @(negedge clk_i);
        reset_i = 1'b0; v_i = 1'b1; w_i = 1'b1; addr_i = 9'd300;
        data_i = '1; w_mask_i = '1; yumi_i = 1'b0;
        for (int k = 0; k < els_lp; k++) begin
            #1;
            chk("init_wr", 192'({ready_o, init_done_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o}),
                192'({1'b0, 1'b0, 1'b1, 1'b1, 9'(k), 64'd0, {64{1'b1}}}));
            @(negedge clk_i);
        end
        v_i = 1'b0;
        #1;
        chk("init_done_rise", 192'({init_done_o, ready_o, mem_v_o}), 192'(3'b110));
        for (int i = 0; i < els_lp; i++) ref_mem[i] = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_state", 192'({ready_o, v_o, init_done_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o}),
            192'(0));
        init_phase();

        step(1'b1, 1'b1, 9'd5, 64'hDEAD_BEEF_0000_0001, '1, 1'b1);
        step(1'b1, 1'b0, 9'd5, '0, '0, 1'b1);
        repeat (3) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        chk("rd_addr5", 192'(last_pop), 192'(64'hDEAD_BEEF_0000_0001));

        step(1'b1, 1'b1, 9'd7, 64'hFFFF_FFFF_FFFF_FFFF, '1, 1'b1);
        step(1'b1, 1'b1, 9'd7, 64'd0, 64'h0000_0000_FFFF_FFFF, 1'b1);
        step(1'b1, 1'b0, 9'd7, '0, '0, 1'b1);
        repeat (3) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        chk("rd_addr7_masked", 192'(last_pop), 192'(64'hFFFF_FFFF_0000_0000));

        n_acc = 0;
        for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 9'(a), '0, '0, 1'b1);
        repeat (3) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        chk("burst_accepts", 192'(n_acc), 192'(16));

        n_acc = 0;
        for (int a = 0; a < 6; a++) step(1'b1, 1'b0, 9'(a + 3), '0, '0, 1'b0);
        chk("backpressure_accepts", 192'(n_acc), 192'(3));
        repeat (5) step(1'b0, 1'b0, '0, '0, '0, 1'b1);

        repeat (300) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)),
                 {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
        end
        repeat (5) step(1'b0, 1'b0, '0, '0, '0, 1'b1);

        // Two returns buffered and one read in flight, then reset in the middle of a cycle.
        step(1'b1, 1'b0, 9'd40, '0, '0, 1'b0);
        step(1'b1, 1'b0, 9'd41, '0, '0, 1'b0);
        step(1'b1, 1'b0, 9'd42, '0, '0, 1'b0);
        @(negedge clk_i);
        v_i = 1'b0;
        #1;
        chk("pre_reset_full", 192'({v_o, ready_o}), 192'(2'b10));
        reset_i = 1'b1;
        #1;
        chk("reset_mid_cycle", 192'({v_o, ready_o, init_done_o, mem_v_o}), 192'(4'b0000));
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk_i);
        init_phase();
        repeat (6) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        step(1'b1, 1'b0, 9'd40, '0, '0, 1'b1);
        repeat (3) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        chk("post_reset_rd", 192'(last_pop), 192'(64'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
